interleaved_complex_accumulator: RTL

//  Accumulates CHANNELS interleaved complex fixed-point streams over a run-time length of frames.
//  One frame = one sample per channel, channel 0 first.

---
 rtl/interleaved_complex_accumulator.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/interleaved_complex_accumulator.sv
// Accumulates CHANNELS interleaved complex streams over a configurable number of frames and
// emits one final (re, im) sum per channel during the last frame of each block.
module interleaved_complex_accumulator #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned MAX_LEN_BITS = 9,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned ACC_W       = DATA_W + MAX_LEN_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      config_valid,
    input  logic [MAX_LEN_BITS:0]     config_length,
    input  logic                      config_repeat,
    input  logic                      abort,
    output logic                      config_error,
    output logic                      busy,
    input  logic signed [DATA_W-1:0]  in_re,
    input  logic signed [DATA_W-1:0]  in_im,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [ACC_W-1:0]   out_re,
    output logic signed [ACC_W-1:0]   out_im,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_channel,
    output logic                      out_last
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [MAX_LEN_BITS:0] MaxLen  = {1'b1, {MAX_LEN_BITS{1'b0}}};
    localparam logic [CH_W-1:0]       LastCh  = CH_W'(CHANNELS - 1);

    state_e                    state_q, state_d;
    logic [MAX_LEN_BITS:0]     length_q;
    logic                      repeat_q;
    logic [CH_W-1:0]           ch_q;
    logic [MAX_LEN_BITS-1:0]   frame_q;
    logic signed [ACC_W-1:0]   acc_re_q [CHANNELS];
    logic signed [ACC_W-1:0]   acc_im_q [CHANNELS];

    logic                      cfg_legal;
    logic                      cfg_ok;
    logic                      cfg_bad;
    logic                      accept;
    logic                      last_frame;
    logic                      last_ch;
    logic                      block_end;
    logic signed [ACC_W-1:0]   base_re, base_im;
    logic signed [ACC_W-1:0]   sum_re, sum_im;

    assign cfg_legal  = (config_length != '0) && (config_length <= MaxLen);
    assign last_frame = ({1'b0, frame_q} == (length_q - 1'b1));
    assign last_ch    = (ch_q == LastCh);
    assign busy       = (state_q == StRun);
    assign in_ready   = busy;

    always_comb begin
        state_d   = state_q;
        cfg_ok    = 1'b0;
        cfg_bad   = 1'b0;
        accept    = 1'b0;
        block_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (config_valid) begin
                    if (cfg_legal) begin
                        cfg_ok  = 1'b1;
                        state_d = StRun;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort wins over a same-cycle sample, which is dropped.
                if (abort) begin
                    state_d = StIdle;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (last_frame && last_ch) begin
                        block_end = 1'b1;
                        if (!repeat_q) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame 0 starts from zero so nothing carries over between blocks.
    always_comb begin
        base_re = (frame_q == '0) ? '0 : acc_re_q[ch_q];
        base_im = (frame_q == '0) ? '0 : acc_im_q[ch_q];
        sum_re  = base_re + {{MAX_LEN_BITS{in_re[DATA_W-1]}}, in_re};
        sum_im  = base_im + {{MAX_LEN_BITS{in_im[DATA_W-1]}}, in_im};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            length_q     <= '0;
            repeat_q     <= 1'b0;
            ch_q         <= '0;
            frame_q      <= '0;
            config_error <= 1'b0;
            out_valid    <= 1'b0;
            out_re       <= '0;
            out_im       <= '0;
            out_channel  <= '0;
            out_last     <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                acc_re_q[i] <= '0;
                acc_im_q[i] <= '0;
            end
        end else begin
            config_error <= cfg_bad;
            out_valid    <= 1'b0;
            if (cfg_ok) begin
                length_q <= config_length;
                repeat_q <= config_repeat;
                ch_q     <= '0;
                frame_q  <= '0;
            end
            if (accept) begin
                acc_re_q[ch_q] <= sum_re;
                acc_im_q[ch_q] <= sum_im;
                if (last_frame) begin
                    out_valid   <= 1'b1;
                    out_re      <= sum_re;
                    out_im      <= sum_im;
                    out_channel <= ch_q;
                    out_last    <= last_ch;
                end
                if (last_ch) begin
                    ch_q    <= '0;
                    frame_q <= block_end ? '0 : frame_q + 1'b1;
                end else begin
                    ch_q <= ch_q + 1'b1;
                end
            end
        end
    end

endmodule
